// File: rtl/pipelined_funnel_shifter.sv
// Pipelined shift/rotate/funnel unit: 2*WIDTH funnel word, one conditional power-of-two shift per stage.
// Optional flags (out_carry, out_zero) are built when SHIFTER_FLAGS_EN is defined.
module pipelined_funnel_shifter #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               mode,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic [$clog2(WIDTH)-1:0] n,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data
`ifdef SHIFTER_FLAGS_EN
  ,
  output logic                     out_carry,
  output logic                     out_zero
`endif
);

  localparam int SHW = $clog2(WIDTH);
  localparam int W2  = 2 * WIDTH;
  localparam logic [SHW:0] K_FULL = (SHW+1)'(WIDTH);

  localparam logic [2:0] MODE_LSR = 3'b000;
  localparam logic [2:0] MODE_ASR = 3'b001;
  localparam logic [2:0] MODE_LSL = 3'b010;
  localparam logic [2:0] MODE_ROR = 3'b011;
  localparam logic [2:0] MODE_ROL = 3'b100;
  localparam logic [2:0] MODE_FSR = 3'b101;

  logic             en;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;
  logic [SHW:0]     k_d;
  logic [SHW:0]     lsl_k;

  // Index 0 is the operand register; index s holds the word after shifting by bits 0..s-1 of k.
  logic [W2-1:0]    word_q  [0:SHW];
  logic [SHW:0]     k_q     [0:SHW];
  logic [SHW:0]     valid_q;
  logic [W2-1:0]    shift_d [1:SHW];

  logic [WIDTH-1:0] out_data_d;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;

  // Whole pipeline advances in lockstep; a stalled result freezes every stage.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;
  assign lsl_k    = K_FULL - {1'b0, n};

  always_comb begin
    hi_d = '0;
    lo_d = '0;
    k_d  = '0;
    case (mode)
      MODE_LSR: begin lo_d = a; k_d = {1'b0, n}; end
      MODE_ASR: begin hi_d = {WIDTH{a[WIDTH-1]}}; lo_d = a; k_d = {1'b0, n}; end
      MODE_LSL: begin hi_d = a; k_d = lsl_k; end
      MODE_ROR: begin hi_d = a; lo_d = a; k_d = {1'b0, n}; end
      MODE_ROL: begin hi_d = a; lo_d = a; k_d = {1'b0, lsl_k[SHW-1:0]}; end
      MODE_FSR: begin hi_d = a; lo_d = b; k_d = {1'b0, n}; end
      default:  ;
    endcase
  end

  genvar gi;
  generate
    for (gi = 1; gi <= SHW; gi++) begin : g_stage
      assign shift_d[gi] = k_q[gi-1][gi-1] ? (word_q[gi-1] >> (1 << (gi-1))) : word_q[gi-1];
    end
  endgenerate

  // Last stage shifts by WIDTH, which just selects the upper half.
  assign out_data_d = k_q[SHW][SHW] ? word_q[SHW][W2-1:WIDTH] : word_q[SHW][WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int s = 0; s <= SHW; s++) begin
        word_q[s] <= '0;
        k_q[s]    <= '0;
      end
    end else if (en) begin
      valid_q[0] <= in_valid;
      word_q[0]  <= {hi_d, lo_d};
      k_q[0]     <= k_d;
      for (int s = 1; s <= SHW; s++) begin
        valid_q[s] <= valid_q[s-1];
        word_q[s]  <= shift_d[s];
        k_q[s]     <= k_q[s-1];
      end
      out_valid_q <= valid_q[SHW];
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef SHIFTER_FLAGS_EN
  logic [SHW-1:0] n_m1;
  logic           carry_d;
  logic [SHW:0]   carry_q;
  logic           out_carry_q;
  logic           out_zero_q;

  assign n_m1 = n - SHW'(1);

  // Carry is the last bit to leave the operand, so it is picked from the inputs up front.
  always_comb begin
    carry_d = 1'b0;
    if (n != '0) begin
      case (mode)
        MODE_LSR, MODE_ASR, MODE_ROR: carry_d = a[n_m1];
        MODE_LSL, MODE_ROL:           carry_d = a[lsl_k[SHW-1:0]];
        MODE_FSR:                     carry_d = b[n_m1];
        default:                      carry_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q     <= '0;
      out_carry_q <= 1'b0;
      out_zero_q  <= 1'b0;
    end else if (en) begin
      carry_q     <= {carry_q[SHW-1:0], carry_d};
      out_carry_q <= carry_q[SHW];
      out_zero_q  <= (out_data_d == '0);
    end
  end

  assign out_carry = out_carry_q;
  assign out_zero  = out_zero_q;
`endif

endmodule

// File: tb/tb_pipelined_funnel_shifter.sv
// Directed self-checking bench for pipelined_funnel_shifter at WIDTH=8.
// Flag checks are compiled in only when SHIFTER_FLAGS_EN is defined.
module tb_pipelined_funnel_shifter;

  localparam int WIDTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] mode;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] n;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
`ifdef SHIFTER_FLAGS_EN
  logic       out_carry;
  logic       out_zero;
`endif

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [2:0] m;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] n;
    logic [7:0] d;
    logic       c;
    logic       z;
  } vec_t;

  always #5 clk = ~clk;

  pipelined_funnel_shifter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .n         (n),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SHIFTER_FLAGS_EN
    ,
    .out_carry (out_carry),
    .out_zero  (out_zero)
`endif
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one op into an idle pipeline and waits (bounded) for its result.
  task automatic run_op(input logic [2:0] m, input logic [7:0] av, input logic [7:0] bv,
                        input logic [2:0] nv, output int lat, output logic [7:0] d,
                        output logic c, output logic z);
    @(negedge clk);
    mode = m; a = av; b = bv; n = nv;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    d = out_data;
`ifdef SHIFTER_FLAGS_EN
    c = out_carry;
    z = out_zero;
`else
    c = 1'b0;
    z = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    mode = 3'b000; a = 8'h00; b = 8'h00; n = 3'd0;
    repeat (2) @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    vectors++;
    if (out_data !== 8'h00) begin miscompares++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
`ifdef SHIFTER_FLAGS_EN
    vectors++;
    if (out_carry !== 1'b0 || out_zero !== 1'b0) begin
      miscompares++; $display("FAIL reset_flags: got carry=%b zero=%b expected 0/0", out_carry, out_zero);
    end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    $display("reset: checked idle outputs and in_ready");
    out_ready = 1'b1;
  endtask

  task automatic test_modes();
    vec_t tab [13];
    int lat;
    logic [7:0] d;
    logic c, z;
    tab = '{
      '{3'b001, 8'h96, 8'h00, 3'd3, 8'hF2, 1'b1, 1'b0},
      '{3'b010, 8'h96, 8'h00, 3'd3, 8'hB0, 1'b0, 1'b0},
      '{3'b100, 8'h96, 8'h00, 3'd3, 8'hB4, 1'b0, 1'b0},
      '{3'b011, 8'h96, 8'h00, 3'd1, 8'h4B, 1'b0, 1'b0},
      '{3'b101, 8'hAB, 8'hCD, 3'd4, 8'hBC, 1'b1, 1'b0},
      '{3'b101, 8'hAB, 8'hCD, 3'd0, 8'hCD, 1'b0, 1'b0},
      '{3'b000, 8'h01, 8'h00, 3'd1, 8'h00, 1'b1, 1'b1},
      '{3'b000, 8'h96, 8'h00, 3'd3, 8'h12, 1'b1, 1'b0},
      '{3'b010, 8'h96, 8'h00, 3'd7, 8'h00, 1'b1, 1'b1},
      '{3'b011, 8'h96, 8'h00, 3'd7, 8'h2D, 1'b0, 1'b0},
      '{3'b100, 8'h96, 8'h00, 3'd7, 8'h4B, 1'b1, 1'b0},
      '{3'b001, 8'h96, 8'h00, 3'd7, 8'hFF, 1'b0, 1'b0},
      '{3'b101, 8'hAB, 8'hCD, 3'd7, 8'h57, 1'b1, 1'b0}
    };
    foreach (tab[i]) begin
      run_op(tab[i].m, tab[i].a, tab[i].b, tab[i].n, lat, d, c, z);
      $display("modes[%0d]: mode=%b a=%h b=%h n=%0d -> data=%h lat=%0d", i, tab[i].m, tab[i].a, tab[i].b, tab[i].n, d, lat);
      vectors++;
      if (lat != 4) begin miscompares++; $display("FAIL modes[%0d]_latency: got %0d expected 4", i, lat); end
      vectors++;
      if (d !== tab[i].d) begin miscompares++; $display("FAIL modes[%0d]_data: got %h expected %h", i, d, tab[i].d); end
`ifdef SHIFTER_FLAGS_EN
      vectors++;
      if (c !== tab[i].c) begin miscompares++; $display("FAIL modes[%0d]_carry: got %b expected %b", i, c, tab[i].c); end
      vectors++;
      if (z !== tab[i].z) begin miscompares++; $display("FAIL modes[%0d]_zero: got %b expected %b", i, z, tab[i].z); end
`endif
    end
  endtask

  task automatic test_zero_shift();
    vec_t tab [8];
    int lat;
    logic [7:0] d;
    logic c, z;
    tab = '{
      '{3'b000, 8'h5A, 8'hA5, 3'd0, 8'h5A, 1'b0, 1'b0},
      '{3'b001, 8'h5A, 8'hA5, 3'd0, 8'h5A, 1'b0, 1'b0},
      '{3'b010, 8'h5A, 8'hA5, 3'd0, 8'h5A, 1'b0, 1'b0},
      '{3'b011, 8'h5A, 8'hA5, 3'd0, 8'h5A, 1'b0, 1'b0},
      '{3'b100, 8'h5A, 8'hA5, 3'd0, 8'h5A, 1'b0, 1'b0},
      '{3'b101, 8'h5A, 8'hA5, 3'd0, 8'hA5, 1'b0, 1'b0},
      '{3'b110, 8'hFF, 8'hFF, 3'd3, 8'h00, 1'b0, 1'b1},
      '{3'b111, 8'h96, 8'hAB, 3'd5, 8'h00, 1'b0, 1'b1}
    };
    foreach (tab[i]) begin
      run_op(tab[i].m, tab[i].a, tab[i].b, tab[i].n, lat, d, c, z);
      $display("zero_shift[%0d]: mode=%b a=%h b=%h n=%0d -> data=%h", i, tab[i].m, tab[i].a, tab[i].b, tab[i].n, d);
      vectors++;
      if (lat != 4) begin miscompares++; $display("FAIL zero_shift[%0d]_latency: got %0d expected 4", i, lat); end
      vectors++;
      if (d !== tab[i].d) begin miscompares++; $display("FAIL zero_shift[%0d]_data: got %h expected %h", i, d, tab[i].d); end
`ifdef SHIFTER_FLAGS_EN
      vectors++;
      if (c !== tab[i].c) begin miscompares++; $display("FAIL zero_shift[%0d]_carry: got %b expected %b", i, c, tab[i].c); end
      vectors++;
      if (z !== tab[i].z) begin miscompares++; $display("FAIL zero_shift[%0d]_zero: got %b expected %b", i, z, tab[i].z); end
`endif
    end
  endtask

  task automatic test_back_to_back();
    vec_t tab [6];
    int i, got, cyc, dcyc, stall_left, extra;
    logic seen;
    logic [7:0] held;
    tab = '{
      '{3'b000, 8'h80, 8'h00, 3'd1, 8'h40, 1'b0, 1'b0},
      '{3'b001, 8'h80, 8'h00, 3'd2, 8'hE0, 1'b0, 1'b0},
      '{3'b010, 8'h03, 8'h00, 3'd3, 8'h18, 1'b0, 1'b0},
      '{3'b011, 8'h12, 8'h00, 3'd4, 8'h21, 1'b0, 1'b0},
      '{3'b100, 8'h81, 8'h00, 3'd1, 8'h03, 1'b0, 1'b0},
      '{3'b101, 8'h12, 8'h34, 3'd4, 8'h23, 1'b0, 1'b0}
    };
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    i = 0; got = 0; cyc = 0; dcyc = 0; stall_left = 0; seen = 1'b0; held = '0;
    fork
      begin
        while (i < 6 && dcyc < 100) begin
          @(negedge clk); dcyc++;
          mode = tab[i].m; a = tab[i].a; b = tab[i].b; n = tab[i].n;
          in_valid = 1'b1;
          #1;
          if (in_ready) i++;
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        while (got < 6 && cyc < 100) begin
          @(negedge clk); cyc++;
          if (out_valid && !seen) begin seen = 1'b1; stall_left = 3; held = out_data; end
          if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
            #1;
            $display("b2b: stall cycle, data=%h in_ready=%b", out_data, in_ready);
            vectors++;
            if (in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_stall_in_ready: got %b expected 0", in_ready); end
            vectors++;
            if (out_valid !== 1'b1 || out_data !== held) begin
              miscompares++; $display("FAIL b2b_stall_hold: got valid=%b data=%h expected valid=1 data=%h", out_valid, out_data, held);
            end
          end else begin
            out_ready = 1'b1;
            if (out_valid) begin
              $display("b2b: result %0d data=%h", got, out_data);
              vectors++;
              if (out_data !== tab[got].d) begin
                miscompares++; $display("FAIL b2b_result[%0d]: got %h expected %h", got, out_data, tab[got].d);
              end
              got++;
            end
          end
        end
      end
    join
    vectors++;
    if (got != 6 || i != 6) begin miscompares++; $display("FAIL b2b_count: got %0d results from %0d accepted, expected 6", got, i); end
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL b2b_stall_seen: got 0 expected 1"); end
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    vectors++;
    if (extra != 0) begin miscompares++; $display("FAIL b2b_extra: got %0d extra results expected 0", extra); end
  endtask

  task automatic test_reset_mid_stream();
    int lat, stale;
    logic [7:0] d;
    logic c, z;
    @(negedge clk);
    out_ready = 1'b1;
    mode = 3'b000; a = 8'hF0; b = 8'h00; n = 3'd0;
    in_valid = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'hF0) begin
      miscompares++; $display("FAIL midrst_pre: got valid=%b data=%h expected valid=1 data=f0", out_valid, out_data);
    end
    rst = 1'b1;
    #1;
    $display("midrst: reset asserted, valid=%b data=%h", out_valid, out_data);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
    vectors++;
    if (out_data !== 8'h00) begin miscompares++; $display("FAIL midrst_out_data: got %h expected 00", out_data); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
`ifdef SHIFTER_FLAGS_EN
    vectors++;
    if (out_carry !== 1'b0 || out_zero !== 1'b0) begin
      miscompares++; $display("FAIL midrst_flags: got carry=%b zero=%b expected 0/0", out_carry, out_zero);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    vectors++;
    if (stale != 0) begin miscompares++; $display("FAIL midrst_stale: got %0d stale results expected 0", stale); end
    run_op(3'b001, 8'h70, 8'h00, 3'd4, lat, d, c, z);
    $display("midrst: post-reset op data=%h lat=%0d", d, lat);
    vectors++;
    if (lat != 4) begin miscompares++; $display("FAIL midrst_latency: got %0d expected 4", lat); end
    vectors++;
    if (d !== 8'h07) begin miscompares++; $display("FAIL midrst_data: got %h expected 07", d); end
`ifdef SHIFTER_FLAGS_EN
    vectors++;
    if (c !== 1'b0 || z !== 1'b0) begin miscompares++; $display("FAIL midrst_flags_after: got carry=%b zero=%b expected 0/0", c, z); end
`endif
  endtask

  initial begin
    test_reset();
    test_modes();
    test_zero_shift();
    test_back_to_back();
    test_reset_mid_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipelined_funnel_shifter.md
# pipelined_funnel_shifter

- Parametrised, pipelined shift unit covering five shift/rotate modes plus a two-operand funnel shift.
- Built on a 2·WIDTH funnel core.
- Accepts one operation per cycle over a valid/ready handshake and returns results in order after a fixed latency.
- Sits between an operand source (datapath register file or test driver) and a result sink that may apply backpressure.

## Interface
Parameters:
- WIDTH, 8, data width; power of two, ≥4. SHW = $clog2(WIDTH) (derived); L = SHW+1 pipeline stages (derived).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid && in_ready at clk edge
- mode  in  3  000 LSR, 001 ASR, 010 LSL, 011 ROR, 100 ROL, 101 FSR, 110/111 reserved
- a  in  WIDTH  primary operand (upper half for FSR)
- b  in  WIDTH  lower half for FSR; ignored otherwise
- n  in  SHW  shift amount, 0..WIDTH-1
- out_valid  out  1  result present
- out_ready  in  1  sink accepts result when out_valid && out_ready
- out_data  out  WIDTH  result
- out_carry  out  1  last bit shifted out (SHIFTER_FLAGS_EN only)
- out_zero  out  1  out_data == 0 (SHIFTER_FLAGS_EN only)

## Operation
Input stage forms a 2·WIDTH word {hi, lo} and an internal amount k (SHW+1 bits). Result is the low WIDTH bits of {hi, lo} >> k.
- LSR: hi=0, lo=a, k=n.
- ASR: hi={WIDTH{a[WIDTH-1]}}, lo=a, k=n.
- ROR: hi=a, lo=a, k=n.
- LSL: hi=a, lo=0, k=WIDTH-n. n=0 gives k=WIDTH and result a.
- ROL: hi=a, lo=a, k=(WIDTH-n) mod WIDTH.
- FSR: hi=a, lo=b, k=n. n=0 gives result b.
- Reserved modes: result 0, carry 0.

Pipeline:
- Stage j (0..SHW) conditionally shifts by 2^j per bit j of k.
- Each stage is registered with its own valid bit; mode/carry bookkeeping travels with the data.
- Global advance enable: en = !out_valid || out_ready. All stages move together when en=1; bubbles are not collapsed.
- in_ready = en, combinational from out_valid/out_ready only, never from in_valid.
- When en=0, every stage register holds. out_data and out_valid stay stable while out_valid && !out_ready.
- Results leave in acceptance order; none are dropped or duplicated.

## Timing
- Latency: an op accepted at edge t appears with out_valid=1 after edge t+L if no stall (WIDTH=8: L=4). Each stall cycle adds one.
- Throughput: 1 op/cycle while out_ready=1.
- Simultaneous accept at the input and drain at the output in the same cycle is legal and required for full throughput.
- Reset: asynchronous; on assertion, all stage valids clear immediately and out_valid=0, out_data=0, out_carry=0, out_zero=0.
- in_ready=1 during reset and from the first edge after release.
- In-flight ops are discarded on reset mid-operation.

## Configuration
SHIFTER_FLAGS_EN
- Defined: out_carry and out_zero exist and are registered alongside out_data.
- out_carry for n=0 is 0. Otherwise:
  - LSR/ASR/ROR: a[n-1].
  - LSL/ROL: a[WIDTH-n].
  - FSR: bit n-1 of {a,b}.
- out_zero = (out_data == 0).
- Undefined: both ports and their pipeline registers are absent; data behaviour is identical.

## Test plan
WIDTH=8 throughout.
- ASR, a=0x96, n=3 -> after 4 cycles out_data=0xF2, out_carry=1, out_zero=0.
- LSL, a=0x96, n=3 -> 0xB0, carry=0; ROL a=0x96 n=3 -> 0xB4; ROR a=0x96 n=1 -> 0x4B, carry=0.
- FSR, a=0xAB, b=0xCD, n=4 -> 0xBC. Then n=0 -> 0xCD. Then LSR a=0x01 n=1 -> 0x00, zero=1, carry=1.
- Stream ops 1..6 back-to-back with out_ready low for 3 cycles once the first result is valid:
  - out_data held stable during the stall.
  - in_ready=0 during the stall.
  - All 6 results delivered in order with no loss.
- Pipeline full, assert rst for 1 cycle mid-stream -> out_valid=0, out_data=0 immediately. No stale result afterwards; the next accepted op emerges after 4 cycles.
- Every mode with n=0 -> a, except FSR -> b. Reserved mode 110 -> 0x00, carry=0.
